gemm_c_tile_reader: RTL



---
 rtl/gemm_pkg.sv | 18 +
 rtl/gemm_c_tile_reader_if.sv | 26 ++
 rtl/gemm_c_tile_unpack.sv | 18 +
 rtl/gemm_c_tile_reader.sv | 86 ++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared sizes, tile-count helper and reader FSM states
package gemm_pkg;
  localparam int RowPar = 4;
  localparam int ColPar = 16;
  localparam int OutDataWidth = 32;
  localparam int AddrWidth = 12;
  localparam int SizeAddrWidth = 32;
  localparam int ReadLatency = 1;
  localparam int TileSize = RowPar * ColPar;
  localparam int PackedOutWidth = TileSize * OutDataWidth;
  localparam int QW = RowPar > 1 ? $clog2(RowPar) : 1;
  localparam int LW = ColPar > 1 ? $clog2(ColPar) : 1;
  localparam int WW = ReadLatency > 1 ? $clog2(ReadLatency) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STREAM, DONE} state_t;
  function automatic logic [SizeAddrWidth-1:0] ceil_div(input logic [SizeAddrWidth-1:0] a, input int b);
    return a / SizeAddrWidth'(b) + SizeAddrWidth'((a % SizeAddrWidth'(b)) != 0);
  endfunction
endpackage

// File: rtl/gemm_c_tile_reader_if.sv
// gemm_c_tile_reader_if: control, SRAM C read port and element stream of the C tile reader
interface gemm_c_tile_reader_if;
  import gemm_pkg::*;
  logic start_i;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic [AddrWidth-1:0] sram_c_addr_o;
  logic sram_c_re_o;
  logic [PackedOutWidth-1:0] sram_c_rdata_i;
  logic [OutDataWidth-1:0] out_data_o;
  logic [SizeAddrWidth-1:0] out_row_o;
  logic [SizeAddrWidth-1:0] out_col_o;
  logic out_last_o;
  logic out_valid_o;
  logic out_ready_i;
  logic busy_o;
  logic done_o;
  modport master (
    input start_i, M_size_i, N_size_i, sram_c_rdata_i, out_ready_i,
    output sram_c_addr_o, sram_c_re_o, out_data_o, out_row_o, out_col_o, out_last_o, out_valid_o, busy_o, done_o
  );
  modport slave (
    output start_i, M_size_i, N_size_i, sram_c_rdata_i, out_ready_i,
    input sram_c_addr_o, sram_c_re_o, out_data_o, out_row_o, out_col_o, out_last_o, out_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/gemm_c_tile_unpack.sv
// gemm_c_tile_unpack: tile register with combinational (q,l) element select
module gemm_c_tile_unpack
  import gemm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic load,
  input  logic [PackedOutWidth-1:0] rdata,
  input  logic [QW-1:0] q,
  input  logic [LW-1:0] l,
  output logic [OutDataWidth-1:0] data
);
  logic [PackedOutWidth-1:0] tile_r;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) tile_r <= '0;
    else if (load) tile_r <= rdata;
  assign data = tile_r[(int'(q) * ColPar + int'(l)) * OutDataWidth +: OutDataWidth];
endmodule

// File: rtl/gemm_c_tile_reader.sv
// gemm_c_tile_reader: fetches packed C tiles from SRAM and streams valid elements row-major
module gemm_c_tile_reader
  import gemm_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  gemm_c_tile_reader_if.master bus
);
  state_t state, nxt;
  logic [SizeAddrWidth-1:0] m_r, n_r, nt_r, row_r, cb_r, colb_r, rbase_r, rem, seg_len, col;
  logic [QW-1:0] q_r;
  logic [LW-1:0] l_r;
  logic [WW-1:0] w_r;
  logic [AddrWidth-1:0] addr_r, cur_addr;
  logic hs, seg_end, row_end, last_row, load;
  assign rem = n_r - colb_r;
  assign seg_len = rem > SizeAddrWidth'(ColPar) ? SizeAddrWidth'(ColPar) : rem;
  assign col = colb_r + SizeAddrWidth'(l_r);
  assign hs = state == STREAM && bus.out_ready_i;
  assign seg_end = SizeAddrWidth'(l_r) == seg_len - 1;
  assign row_end = cb_r == nt_r - 1;
  assign last_row = row_r == m_r - 1;
  assign cur_addr = AddrWidth'(rbase_r + cb_r);
  assign load = state == WAIT && w_r == WW'(ReadLatency - 1);
  always_comb begin
    nxt = state;
    bus.sram_c_re_o = state == ISSUE;
    bus.out_valid_o = state == STREAM;
    bus.busy_o = state == ISSUE || state == WAIT || state == STREAM;
    bus.done_o = state == DONE;
    bus.sram_c_addr_o = state == ISSUE ? cur_addr : addr_r;
    bus.out_row_o = row_r;
    bus.out_col_o = col;
    bus.out_last_o = state == STREAM && last_row && col == n_r - 1;
    unique case (state)
      IDLE: if (bus.start_i) nxt = (bus.M_size_i == '0 || bus.N_size_i == '0) ? DONE : ISSUE;
      ISSUE: nxt = WAIT;
      WAIT: if (load) nxt = STREAM;
      STREAM: if (hs && seg_end) nxt = (row_end && last_row) ? DONE : ISSUE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      {m_r, n_r, nt_r, row_r, cb_r, colb_r, rbase_r} <= '0;
      q_r <= '0;
      l_r <= '0;
      w_r <= '0;
      addr_r <= '0;
    end else begin
      state <= nxt;
      w_r <= state == WAIT ? w_r + 1'b1 : '0;
      if (state == ISSUE) addr_r <= cur_addr;
      if (state == IDLE && bus.start_i) begin
        m_r <= bus.M_size_i;
        n_r <= bus.N_size_i;
        nt_r <= ceil_div(bus.N_size_i, ColPar);
        {row_r, cb_r, colb_r, rbase_r} <= '0;
        q_r <= '0;
        l_r <= '0;
      end
      if (hs) begin
        l_r <= seg_end ? '0 : l_r + 1'b1;
        if (seg_end) begin
          cb_r <= row_end ? '0 : cb_r + 1;
          colb_r <= row_end ? '0 : colb_r + SizeAddrWidth'(ColPar);
          if (row_end && !last_row) begin
            row_r <= row_r + 1;
            q_r <= q_r == QW'(RowPar - 1) ? '0 : q_r + 1'b1;
            if (q_r == QW'(RowPar - 1)) rbase_r <= rbase_r + nt_r;
          end
        end
      end
    end
  gemm_c_tile_unpack u_unpack (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .load(load),
    .rdata(bus.sram_c_rdata_i),
    .q(q_r),
    .l(l_r),
    .data(bus.out_data_o)
  );
endmodule
